audio_pll_supervisor: RTL and testbench

//  Sequences the audio PLL (50 MHz refclk -> 12.288 MHz audio clock) from reset to a verified stable lock.
//  - Pulses the PLL reset and waits for lock, with a timeout and a bounded number of retries.
//  - Releases the downstream audio reset only after lock has held for a programmable time.
//  - Reacquires lock automatically if it is lost.
//  - Runs on the free-running refclk domain. It never runs on the PLL output.

---
 rtl/audio_pll_supervisor.sv | 169 ++++++++++++++++
 tb/tb_audio_pll_supervisor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_pll_supervisor.sv
// Audio PLL supervisor.
//
// Brings the audio PLL (50 MHz refclk -> 12.288 MHz) from reset to a verified, stable lock, then
// releases the downstream audio reset. Pulses the PLL reset, waits for lock with a timeout and a
// bounded number of retries, requires lock to hold for STABLE_CYC cycles, and reacquires
// automatically if lock is lost. Runs entirely on refclk, never on the PLL output.
//
// Ports:
//   refclk       in   free-running reference clock, the only clock
//   rst_n        in   synchronous active-low reset
//   pll_locked   in   PLL lock flag, asynchronous to refclk
//   restart      in   single-cycle pulse, restarts the sequence from any state
//   pll_rst      out  active-high PLL reset (RESET_PLL, FAULT)
//   audio_rst_n  out  active-low audio reset, released only in RUN
//   ready        out  high while in RUN
//   fault        out  high while in FAULT
//   retry_cnt    out  failed lock attempts in the current sequence
//   state_dbg    out  state encoding: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN, 4 FAULT
module audio_pll_supervisor #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned STABLE_CYC       = 1024,
  parameter int unsigned MAX_RETRIES      = 3,
  parameter int unsigned CNT_W            = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       audio_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_dbg
);

  // Elaboration-time parameter sanity checks.
  if (RST_PULSE_CYC == 0 || LOCK_TIMEOUT_CYC == 0 || STABLE_CYC == 0 || CNT_W == 0) begin
    : gen_zero_param
    $error("audio_pll_supervisor: cycle parameters and CNT_W must be non-zero");
  end
  if (MAX_RETRIES > 15) begin : gen_bad_retries
    $error("audio_pll_supervisor: MAX_RETRIES must be in 0..15");
  end
  if (CNT_W < 32 && (RST_PULSE_CYC > (64'd1 << CNT_W) || LOCK_TIMEOUT_CYC > (64'd1 << CNT_W) ||
                     STABLE_CYC > (64'd1 << CNT_W))) begin : gen_cnt_too_narrow
    $error("audio_pll_supervisor: CNT_W too narrow for the cycle parameters");
  end

  localparam logic [CNT_W-1:0] RstTc     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TimeoutTc = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] StableTc  = CNT_W'(STABLE_CYC - 1);
  localparam logic [3:0]       MaxRetry  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StResetPll  = 3'd0,
    StWaitLock  = 3'd1,
    StStabilize = 3'd2,
    StRun       = 3'd3,
    StFault     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             lock_meta_q, lock_s_q;
  logic             pll_rst_q, audio_rst_n_q, ready_q, fault_q;

  // Next-state logic. restart outranks every transition, including a coincident timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = StResetPll;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StResetPll: begin
          if (cnt_q == RstTc) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          if (lock_s_q) begin
            state_d = StStabilize;
            cnt_d   = '0;
          end else if (cnt_q == TimeoutTc) begin
            cnt_d = '0;
            if (retry_q >= MaxRetry) begin
              state_d = StFault;
            end else begin
              state_d = StResetPll;
              retry_d = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StStabilize: begin
          // Any drop restarts the timeout window without charging a retry.
          if (!lock_s_q) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == StableTc) begin
            state_d = StRun;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (!lock_s_q) begin
            state_d = StResetPll;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        StFault: begin
          cnt_d = '0;
        end
        default: begin
          state_d = StResetPll;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are registered from state_d so they always match a decode of state_q.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
      state_q       <= StResetPll;
      cnt_q         <= '0;
      retry_q       <= '0;
      pll_rst_q     <= 1'b1;
      audio_rst_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      lock_meta_q   <= pll_locked;
      lock_s_q      <= lock_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pll_rst_q     <= (state_d == StResetPll) || (state_d == StFault);
      audio_rst_n_q <= (state_d == StRun);
      ready_q       <= (state_d == StRun);
      fault_q       <= (state_d == StFault);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign audio_rst_n = audio_rst_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_cnt   = retry_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_audio_pll_supervisor.sv
// Self-checking bench for audio_pll_supervisor with small timing parameters.
// Each scenario pushes its expected per-cycle output snapshot timeline onto a scoreboard queue,
// then pops and compares one entry per refclk cycle, sampled 1 ns after the rising edge.
module tb_audio_pll_supervisor;

  localparam int unsigned RstPulse = 4;
  localparam int unsigned Timeout  = 20;
  localparam int unsigned Stable   = 8;
  localparam int unsigned MaxRetry = 2;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       audio_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [2:0] state_dbg;

  audio_pll_supervisor #(
    .RST_PULSE_CYC   (RstPulse),
    .LOCK_TIMEOUT_CYC(Timeout),
    .STABLE_CYC      (Stable),
    .MAX_RETRIES     (MaxRetry),
    .CNT_W           (16)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .audio_rst_n(audio_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state_dbg  (state_dbg)
  );

  always #5 refclk = ~refclk;

  // Snapshot: {state, pll_rst, audio_rst_n, ready, fault, retry_cnt}
  typedef logic [10:0] snap_t;

  snap_t exp_q[$];
  snap_t obs;
  int    n_pass  = 0;
  int    n_total = 0;

  assign obs = {state_dbg, pll_rst, audio_rst_n, ready, fault, retry_cnt};

  // Expected outputs for a given state and retry count.
  function automatic snap_t mk(int st, int rc);
    logic pr, arn, rdy, flt;
    pr  = (st == 0) || (st == 4);
    arn = (st == 3);
    rdy = (st == 3);
    flt = (st == 4);
    return {3'(st), pr, arn, rdy, flt, 4'(rc)};
  endfunction

  // Expected snapshot when lock never arrives, k cycles after reset release.
  function automatic snap_t no_lock_exp(int k);
    if (k >= 72) return mk(4, 2);
    return mk(((k % 24) < 4) ? 0 : 1, k / 24);
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Leaves the DUT just after a reset edge with rst_n still low.
  task automatic apply_reset();
    rst_n      = 1'b0;
    restart    = 1'b0;
    pll_locked = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    snap_t e;
    apply_reset();
    n_total++;
    if (obs !== mk(0, 0)) $display("FAIL reset_state: got %h, expected %h", obs, mk(0, 0));
    else n_pass++;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) exp_q.push_back(mk((k < 4) ? 0 : 1, 0));
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_total++;
      if (obs !== e) $display("FAIL reset_release cycle %0d: got %h, expected %h", k, obs, e);
      else n_pass++;
    end
  endtask

  // Lock rises 5 cycles into WAIT_LOCK (cycle 9): STABILIZE at 12, RUN at 20.
  task automatic test_normal_lock();
    snap_t e;
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 25; k++)
      exp_q.push_back(mk((k < 4) ? 0 : (k < 12) ? 1 : (k < 20) ? 2 : 3, 0));
    for (int k = 1; k <= 25; k++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_total++;
      if (obs !== e) $display("FAIL normal_lock cycle %0d: got %h, expected %h", k, obs, e);
      else n_pass++;
      pll_locked = (k >= 9);
    end
  endtask

  // Continues from RUN: drop lock, reacquire 8 cycles later.
  task automatic test_loss_in_run();
    snap_t e;
    pll_locked = 1'b0;
    for (int j = 1; j <= 22; j++)
      exp_q.push_back(mk((j <= 2) ? 3 : (j <= 6) ? 0 : (j <= 10) ? 1 : (j <= 18) ? 2 : 3, 0));
    for (int j = 1; j <= 22; j++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_total++;
      if (obs !== e) $display("FAIL loss_in_run cycle %0d: got %h, expected %h", j, obs, e);
      else n_pass++;
      pll_locked = (j >= 8);
    end
  endtask

  task automatic test_no_lock();
    snap_t e;
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 80; k++) exp_q.push_back(no_lock_exp(k));
    for (int k = 1; k <= 80; k++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_total++;
      if (obs !== e) $display("FAIL no_lock cycle %0d: got %h, expected %h", k, obs, e);
      else n_pass++;
    end
  endtask

  // Lock high 5 cycles, low 1, then high: STABILIZE 12..16, WAIT 17, STABILIZE 18..25, RUN 26.
  task automatic test_glitch();
    snap_t e;
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++)
      exp_q.push_back(mk((k < 4) ? 0 : (k < 12) ? 1 : (k < 17) ? 2 : (k < 18) ? 1 :
                         (k < 26) ? 2 : 3, 0));
    for (int k = 1; k <= 30; k++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_total++;
      if (obs !== e) $display("FAIL glitch cycle %0d: got %h, expected %h", k, obs, e);
      else n_pass++;
      pll_locked = (k >= 9) && (k != 14);
    end
  endtask

  // Reach FAULT, pulse restart during cycle 75, new sequence starts at cycle 76.
  task automatic test_fault_restart();
    snap_t e;
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 82; k++)
      exp_q.push_back((k <= 75) ? no_lock_exp(k) : mk((k - 76 < 4) ? 0 : 1, 0));
    for (int k = 1; k <= 82; k++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_total++;
      if (obs !== e) $display("FAIL fault_restart cycle %0d: got %h, expected %h", k, obs, e);
      else n_pass++;
      restart = (k == 75);
    end
  endtask

  // restart lands on the final timeout edge (72): must restart, never FAULT.
  task automatic test_restart_at_timeout();
    snap_t e;
    apply_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 100; k++)
      exp_q.push_back((k < 72) ? no_lock_exp(k) :
                      mk((((k - 72) % 24) < 4) ? 0 : 1, (k - 72) / 24));
    for (int k = 1; k <= 100; k++) begin
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_total++;
      if (obs !== e) $display("FAIL restart_timeout cycle %0d: got %h, expected %h", k, obs, e);
      else n_pass++;
      restart = (k == 71);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    test_reset();
    test_normal_lock();
    test_loss_in_run();
    test_no_lock();
    test_glitch();
    test_fault_restart();
    test_restart_at_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
